// File: rtl/cond_logic_pipe_if.sv
// Bundle of Execute-stage controls and conditional-execution results.
// The "slave" modport is the conditional-logic pipe; "master" is whoever drives it.
interface cond_logic_pipe_if #(
    parameter int PIPE_DEPTH = 2,
    parameter int CNT_W      = 16
);
    logic                  ValidE;
    logic                  StallE;
    logic                  FlushE;
    logic                  PCS;
    logic                  RegW;
    logic                  MemW;
    logic [1:0]            FlagW;
    logic [3:0]            Cond;
    logic [3:0]            ALUFlags;
    logic                  CntClr;
    logic                  PCSrc;
    logic                  CondEx;
    logic [3:0]            Flags;
    logic [PIPE_DEPTH-1:0] RegWritePipe;
    logic                  MemWriteM;
    logic [CNT_W-1:0]      ExecCnt;
    logic [CNT_W-1:0]      AnnulCnt;

    modport master (
        output ValidE, StallE, FlushE, PCS, RegW, MemW, FlagW, Cond, ALUFlags, CntClr,
        input  PCSrc, CondEx, Flags, RegWritePipe, MemWriteM, ExecCnt, AnnulCnt
    );

    modport slave (
        input  ValidE, StallE, FlushE, PCS, RegW, MemW, FlagW, Cond, ALUFlags, CntClr,
        output PCSrc, CondEx, Flags, RegWritePipe, MemWriteM, ExecCnt, AnnulCnt
    );
endinterface

// File: rtl/cond_logic_pipe.sv
// Execute-stage ARM conditional logic: NZCV register, condition decode, qualified
// RegWrite/MemWrite pipe with stall/flush, and saturating executed/annulled counters.
module cond_logic_pipe #(
    parameter int         PIPE_DEPTH  = 2,
    parameter int         CNT_W       = 16,
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    cond_logic_pipe_if.slave     bus
);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic cond_decode(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, r;
        {n, z, c, v} = nzcv;
        case (cond)
            4'b0000: r = z;
            4'b0001: r = ~z;
            4'b0010: r = c;
            4'b0011: r = ~c;
            4'b0100: r = n;
            4'b0101: r = ~n;
            4'b0110: r = v;
            4'b0111: r = ~v;
            4'b1000: r = c & ~z;
            4'b1001: r = ~c | z;
            4'b1010: r = ~(n ^ v);
            4'b1011: r = n ^ v;
            4'b1100: r = ~z & ~(n ^ v);
            4'b1101: r = z | (n ^ v);
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic [3:0]            flags_q, flags_d;
    logic [PIPE_DEPTH-1:0] pipe_q, pipe_d;
    logic                  mem_q, mem_d;
    logic [CNT_W-1:0]      exec_q, exec_d;
    logic [CNT_W-1:0]      annul_q, annul_d;
    logic                  cond_ex_s, adv_s, live_s, ex_s;

    // Qualify the Execute slot; decode uses the committed flags, never ALUFlags.
    always_comb begin
        cond_ex_s = cond_decode(bus.Cond, flags_q);
        adv_s     = ~bus.StallE;
        live_s    = bus.ValidE & ~bus.FlushE & adv_s;
        ex_s      = live_s & cond_ex_s;
    end

    // Next state: everything holds unless the pipe advances.
    always_comb begin
        flags_d = flags_q;
        pipe_d  = pipe_q;
        mem_d   = mem_q;
        exec_d  = exec_q;
        annul_d = annul_q;
        if (adv_s) begin
            if (ex_s & bus.FlagW[1]) flags_d[3:2] = bus.ALUFlags[3:2];
            else                     flags_d[3:2] = flags_q[3:2];
            if (ex_s & bus.FlagW[0]) flags_d[1:0] = bus.ALUFlags[1:0];
            else                     flags_d[1:0] = flags_q[1:0];
            for (int k = 1; k < PIPE_DEPTH; k++) begin
                pipe_d[k] = pipe_q[k-1];
            end
            pipe_d[0] = bus.RegW & ex_s;
            mem_d     = bus.MemW & ex_s;
            // Clear wins over a same-cycle increment; counters stick at all-ones.
            if (bus.CntClr) begin
                exec_d  = CNT_ZERO;
                annul_d = CNT_ZERO;
            end else begin
                if (ex_s && (exec_q != CNT_MAX)) exec_d = exec_q + CNT_ONE;
                else                             exec_d = exec_q;
                if (live_s && !cond_ex_s && (annul_q != CNT_MAX)) annul_d = annul_q + CNT_ONE;
                else                                              annul_d = annul_q;
            end
        end else begin
            flags_d = flags_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            flags_q <= RESET_FLAGS;
            pipe_q  <= {PIPE_DEPTH{1'b0}};
            mem_q   <= 1'b0;
            exec_q  <= CNT_ZERO;
            annul_q <= CNT_ZERO;
        end else begin
            flags_q <= flags_d;
            pipe_q  <= pipe_d;
            mem_q   <= mem_d;
            exec_q  <= exec_d;
            annul_q <= annul_d;
        end
    end

    assign bus.CondEx       = cond_ex_s;
    assign bus.PCSrc        = bus.PCS & ex_s;
    assign bus.Flags        = flags_q;
    assign bus.RegWritePipe = pipe_q;
    assign bus.MemWriteM    = mem_q;
    assign bus.ExecCnt      = exec_q;
    assign bus.AnnulCnt     = annul_q;
endmodule
